decode_stage_pipe: RTL

- Registered, handshaked MIPS instruction-decode stage that replaces the purely combinational decoder.
- Accepts one fetched instruction per cycle from IF.
- Produces a registered bundle of decoded fields and control signals for EX.
- Owns load-use stall insertion, flush, and illegal-opcode flagging.

---
 rtl/decode_stage_pipe.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/decode_stage_pipe.sv
// Registered MIPS decode stage with valid/ready handshakes on both sides.
// Inserts one-cycle load-use bubbles, honours flush, flags illegal encodings.
module decode_stage_pipe #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int ALU_CTRL_W = 4,
  parameter int HAZARD_EN  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     instr,
  input  logic [DATA_W-1:0]     pc,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_pc,
  output logic [REG_ADDR_W-1:0] rs,
  output logic [REG_ADDR_W-1:0] rt,
  output logic [REG_ADDR_W-1:0] wr_reg,
  output logic [4:0]            shamt,
  output logic [DATA_W-1:0]     imm_ext,
  output logic [DATA_W-1:0]     jump_target,
  output logic [ALU_CTRL_W-1:0] alu_ctr,
  output logic                  alu_src,
  output logic                  reg_write,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic                  branch,
  output logic                  branch_ne,
  output logic                  jump,
  output logic                  link,
  output logic                  illegal
);

  localparam logic [ALU_CTRL_W-1:0] ALU_ADD = ALU_CTRL_W'(4'b0000);
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB = ALU_CTRL_W'(4'b0001);
  localparam logic [ALU_CTRL_W-1:0] ALU_SLL = ALU_CTRL_W'(4'b0100);
  localparam logic [ALU_CTRL_W-1:0] ALU_SLT = ALU_CTRL_W'(4'b0111);
  localparam logic [ALU_CTRL_W-1:0] ALU_AND = ALU_CTRL_W'(4'b1001);
  localparam logic [ALU_CTRL_W-1:0] ALU_OR  = ALU_CTRL_W'(4'b1010);
  localparam logic [ALU_CTRL_W-1:0] ALU_NOR = ALU_CTRL_W'(4'b1100);

  logic [5:0]            op;
  logic [5:0]            fn;
  logic [REG_ADDR_W-1:0] in_rs;
  logic [REG_ADDR_W-1:0] in_rt;

  assign op    = instr[31:26];
  assign fn    = instr[5:0];
  assign in_rs = REG_ADDR_W'(instr[25:21]);
  assign in_rt = REG_ADDR_W'(instr[20:16]);

  logic [ALU_CTRL_W-1:0] d_alu;
  logic [REG_ADDR_W-1:0] d_wr;
  logic d_src, d_rw, d_mr, d_mw, d_br, d_bne;
  logic d_j, d_link, d_ill, d_zext;

  always_comb begin
    d_alu  = ALU_ADD;
    d_wr   = in_rt;
    d_src  = 1'b0;
    d_rw   = 1'b0;
    d_mr   = 1'b0;
    d_mw   = 1'b0;
    d_br   = 1'b0;
    d_bne  = 1'b0;
    d_j    = 1'b0;
    d_link = 1'b0;
    d_ill  = 1'b0;
    d_zext = 1'b0;
    unique case (op)
      6'b000000: begin
        d_wr = REG_ADDR_W'(instr[15:11]);
        d_rw = 1'b1;
        unique case (fn)
          6'b100000, 6'b100001: d_alu = ALU_ADD;
          6'b100010, 6'b100011: d_alu = ALU_SUB;
          6'b100100: d_alu = ALU_AND;
          6'b100101: d_alu = ALU_OR;
          6'b100111: d_alu = ALU_NOR;
          6'b101010: d_alu = ALU_SLT;
          6'b000000: d_alu = ALU_SLL;
          default: begin
            d_ill = 1'b1;
            d_rw  = 1'b0;
          end
        endcase
      end
      6'b001000, 6'b001001: begin
        d_src = 1'b1;
        d_rw  = 1'b1;
      end
      6'b001010: begin
        d_alu = ALU_SLT;
        d_src = 1'b1;
        d_rw  = 1'b1;
      end
      6'b001100: begin
        d_alu  = ALU_AND;
        d_src  = 1'b1;
        d_rw   = 1'b1;
        d_zext = 1'b1;
      end
      6'b001101: begin
        d_alu  = ALU_OR;
        d_src  = 1'b1;
        d_rw   = 1'b1;
        d_zext = 1'b1;
      end
      6'b100011: begin
        d_src = 1'b1;
        d_rw  = 1'b1;
        d_mr  = 1'b1;
      end
      6'b101011: begin
        d_src = 1'b1;
        d_mw  = 1'b1;
      end
      6'b000100: begin
        d_alu = ALU_SUB;
        d_br  = 1'b1;
      end
      6'b000101: begin
        d_alu = ALU_SUB;
        d_br  = 1'b1;
        d_bne = 1'b1;
      end
      6'b000010: d_j = 1'b1;
      6'b000011: begin
        d_j    = 1'b1;
        d_link = 1'b1;
        d_rw   = 1'b1;
        d_wr   = REG_ADDR_W'(31);
      end
      default: d_ill = 1'b1;
    endcase
  end

  // Only formats that actually source rt may stall on a match against it.
  logic reads_rt;
  logic hazard;
  logic slot_free;
  logic take;

  assign reads_rt = (op == 6'b000000) | (op == 6'b000100) |
                    (op == 6'b000101) | (op == 6'b101011);

  assign hazard = (HAZARD_EN != 0) & out_valid & mem_read &
                  (wr_reg != '0) & in_valid &
                  ((wr_reg == in_rs) | ((wr_reg == in_rt) & reads_rt));

  assign slot_free = ~out_valid | out_ready;
  assign in_ready  = slot_free & ~hazard & ~flush;
  assign take      = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_pc      <= '0;
      rs          <= '0;
      rt          <= '0;
      wr_reg      <= '0;
      shamt       <= '0;
      imm_ext     <= '0;
      jump_target <= '0;
      alu_ctr     <= '0;
      alu_src     <= 1'b0;
      reg_write   <= 1'b0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      branch      <= 1'b0;
      branch_ne   <= 1'b0;
      jump        <= 1'b0;
      link        <= 1'b0;
      illegal     <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (slot_free) begin
      out_valid <= take;
      if (take) begin
        out_pc      <= pc;
        rs          <= in_rs;
        rt          <= in_rt;
        wr_reg      <= d_wr;
        shamt       <= instr[10:6];
        imm_ext     <= d_zext ? DATA_W'({16'h0, instr[15:0]})
                              : DATA_W'({{16{instr[15]}}, instr[15:0]});
        jump_target <= DATA_W'({pc[31:28], instr[25:0], 2'b00});
        alu_ctr     <= d_alu;
        alu_src     <= d_src;
        reg_write   <= d_rw;
        mem_read    <= d_mr;
        mem_write   <= d_mw;
        branch      <= d_br;
        branch_ne   <= d_bne;
        jump        <= d_j;
        link        <= d_link;
        illegal     <= d_ill;
      end
    end
  end

endmodule
